// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction prefetch slice.
package fetch_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned ADDR_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    typedef enum logic {
        RUN,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order {pc, inst} buffer with flush; DEPTH must be a power of two.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  fetch_entry_t             wr_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction prefetcher: issues sequential fetches, buffers responses, drains on redirect.
// Define PREFETCH_PERF_EN to add the perf_stall_cnt output.
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
`ifdef PREFETCH_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    fetch_state_t      state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     out_next;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              room;
    logic              grant;
    logic              resp_hit;
    logic              resp_take;
    logic              pop;
    logic [ADDR_W-1:0] target_pc;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    assign room       = !fifo_full && (({1'b0, fifo_count} + {1'b0, outstanding}) < DEPTH_C);
    assign imem_req   = rst_n && (state == RUN) && !redirect && room;
    assign imem_addr  = fetch_pc;
    assign grant      = imem_req && imem_gnt;
    // Responses with nothing outstanding are a protocol error and never touch state.
    assign resp_hit   = imem_rvalid && (outstanding != '0);
    assign resp_take  = resp_hit && (state == RUN) && !redirect;
    assign pop        = inst_valid && inst_ready;
    assign target_pc  = redirect_pc & 32'hFFFF_FFFC;
    assign push_entry = '{pc: resp_pc, inst: imem_rdata};

    assign inst_valid = !fifo_empty;
    assign inst       = head.inst;
    assign inst_pc    = head.pc;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (resp_take),
        .wr_data (push_entry),
        .pop     (pop),
        .flush   (redirect),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        out_next = outstanding;
        if (grant && !resp_hit) begin
            out_next = outstanding + 1'b1;
        end else if (resp_hit && !grant) begin
            out_next = outstanding - 1'b1;
        end
    end

    // resp_pc follows issue order: all requests in flight in RUN were issued sequentially
    // since the last redirect, so the next response PC is a running counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
        end else begin
            outstanding <= out_next;
            if (redirect) begin
                fetch_pc <= target_pc;
                resp_pc  <= target_pc;
                state    <= (out_next != '0) ? DRAIN : RUN;
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (resp_take) begin
                    resp_pc <= resp_pc + 32'd4;
                end
                if ((state == DRAIN) && (out_next == '0)) begin
                    state <= RUN;
                end
            end
        end
    end

`ifdef PREFETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
        end else if (inst_ready && !inst_valid && (perf_stall_cnt != '1)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch (DEPTH=2) with a 1-cycle-latency memory responder.
module tb_fetch_prefetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
`ifdef PREFETCH_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic        mem_on = 1'b1;
    logic [31:0] mem_q[$];
    logic [31:0] grants[$];
    logic [31:0] pops_pc[$];
    logic [31:0] pops_inst[$];

    fetch_prefetch #(
        .DEPTH    (2),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
`ifdef PREFETCH_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle, entered and left at a falling edge. Memory words are addr ^ DEAD_0000.
    task automatic cyc();
        logic        g;
        logic        p;
        logic [31:0] ga;
        logic [31:0] pp;
        logic [31:0] pi;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (mem_on && (mem_q.size() > 0)) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_q[0] ^ 32'hDEAD_0000;
        end
        #1;
        g  = imem_req && imem_gnt;
        ga = imem_addr;
        p  = inst_valid && inst_ready;
        pp = inst_pc;
        pi = inst;
        @(posedge clk);
        if (imem_rvalid) void'(mem_q.pop_front());
        if (g) begin
            mem_q.push_back(ga);
            grants.push_back(ga);
        end
        if (p) begin
            pops_pc.push_back(pp);
            pops_inst.push_back(pi);
        end
        @(negedge clk);
        imem_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        inst_ready  = 1'b0;
        mem_on      = 1'b1;
        mem_q.delete();
        grants.delete();
        pops_pc.delete();
        pops_inst.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        @(negedge clk);

        // Reset values and first request
        rst_n = 1'b0;
        #1;
        check("rst_req",   32'(imem_req),   32'd0);
        check("rst_addr",  imem_addr,       32'h0000_0000);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst",  inst,            32'h0000_0000);
        check("rst_pc",    inst_pc,         32'h0000_0000);
`ifdef PREFETCH_PERF_EN
        check("rst_perf",  perf_stall_cnt,  32'd0);
`endif
        @(negedge clk);
        do_reset();
        #1;
        check("rel_req", 32'(imem_req), 32'd1);
        @(negedge clk);

        // Streaming fetch with the core always ready
        do_reset();
        imem_gnt   = 1'b1;
        inst_ready = 1'b1;
        repeat (16) cyc();
        check("t1_ngnt_ge4", 32'(grants.size() >= 4), 32'd1);
        check("t1_npop_ge4", 32'(pops_pc.size() >= 4), 32'd1);
        check("t1_gnt0", grants[0], 32'h0000_0000);
        check("t1_gnt1", grants[1], 32'h0000_0004);
        check("t1_gnt2", grants[2], 32'h0000_0008);
        check("t1_gnt3", grants[3], 32'h0000_000C);
        check("t1_pc0",  pops_pc[0], 32'h0000_0000);
        check("t1_pc1",  pops_pc[1], 32'h0000_0004);
        check("t1_pc2",  pops_pc[2], 32'h0000_0008);
        check("t1_pc3",  pops_pc[3], 32'h0000_000C);
        check("t1_in0",  pops_inst[0], 32'hDEAD_0000);
        check("t1_in3",  pops_inst[3], 32'hDEAD_000C);

        // Core stalled: buffer fills after two grants, then resumes after one pop
        do_reset();
        imem_gnt = 1'b1;
        repeat (8) cyc();
        check("t2_ngnt",  32'(grants.size()), 32'd2);
        check("t2_req",   32'(imem_req),      32'd0);
        check("t2_valid", 32'(inst_valid),    32'd1);
        check("t2_headpc", inst_pc,           32'h0000_0000);
        inst_ready = 1'b1;
        cyc();
        inst_ready = 1'b0;
        #1;
        check("t2_req_after_pop", 32'(imem_req), 32'd1);
        check("t2_addr_after_pop", imem_addr, 32'h0000_0008);
        @(negedge clk);

        // Redirect with two outstanding requests
        do_reset();
        imem_gnt   = 1'b1;
        inst_ready = 1'b1;
        mem_on     = 1'b0;
        repeat (3) cyc();
        check("t3_full_req", 32'(imem_req), 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        cyc();
        redirect = 1'b0;
        check("t3_drain_req",   32'(imem_req),   32'd0);
        check("t3_flush_valid", 32'(inst_valid), 32'd0);
        mem_on = 1'b1;
        grants.delete();
        pops_pc.delete();
        pops_inst.delete();
        cyc();
        check("t3_drop0_valid", 32'(inst_valid), 32'd0);
        check("t3_drop0_req",   32'(imem_req),   32'd0);
        cyc();
        check("t3_drop1_valid", 32'(inst_valid), 32'd0);
        check("t3_run_req",     32'(imem_req),   32'd1);
        check("t3_run_addr",    imem_addr,       32'h0000_0100);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cyc();
            if (pops_pc.size() > 0) found = 1'b1;
        end
        check("t3_new_resp", 32'(found), 32'd1);
        check("t3_new_pc",   pops_pc[0],   32'h0000_0100);
        check("t3_new_inst", pops_inst[0], 32'hDEAD_0100);
        check("t3_new_gnt",  grants[0],    32'h0000_0100);

        // Redirect to the top word: fetch address wraps to zero
        do_reset();
        imem_gnt    = 1'b1;
        inst_ready  = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        cyc();
        redirect = 1'b0;
        check("t4_addr", imem_addr, 32'hFFFF_FFFC);
        grants.delete();
        pops_pc.delete();
        pops_inst.delete();
        repeat (8) cyc();
        check("t4_gnt0", grants[0],    32'hFFFF_FFFC);
        check("t4_gnt1", grants[1],    32'h0000_0000);
        check("t4_pc0",  pops_pc[0],   32'hFFFF_FFFC);
        check("t4_pc1",  pops_pc[1],   32'h0000_0000);
        check("t4_in0",  pops_inst[0], 32'h2152_FFFC);

        // Asynchronous reset while draining
        do_reset();
        imem_gnt   = 1'b1;
        inst_ready = 1'b1;
        mem_on     = 1'b0;
        repeat (3) cyc();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        cyc();
        redirect = 1'b0;
        check("t5_drain_addr", imem_addr, 32'h0000_0200);
        #2;
        rst_n = 1'b0;
        mem_q.delete();
        #1;
        check("t5_req",   32'(imem_req),   32'd0);
        check("t5_addr",  imem_addr,       32'h0000_0000);
        check("t5_valid", 32'(inst_valid), 32'd0);
        check("t5_inst",  inst,            32'h0000_0000);
        check("t5_pc",    inst_pc,         32'h0000_0000);
        @(negedge clk);
        rst_n  = 1'b1;
        mem_on = 1'b1;
        grants.delete();
        pops_pc.delete();
        pops_inst.delete();
        repeat (6) cyc();
        check("t5_gnt0", grants[0],  32'h0000_0000);
        check("t5_pc0",  pops_pc[0], 32'h0000_0000);

`ifdef PREFETCH_PERF_EN
        // Stall counter: five ready cycles with nothing fetched
        do_reset();
        imem_gnt   = 1'b0;
        inst_ready = 1'b1;
        repeat (5) cyc();
        inst_ready = 1'b0;
        #1;
        check("t6_perf", perf_stall_cnt, 32'd5);
        @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
